// File: rtl/mem_ctrl_pkg.sv
// Shared types for the round-robin data-memory controller.
// Holds the channel state encoding and the width helper for consumer indices.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    CH_IDLE       = 2'd0,
    CH_READ_WAIT  = 2'd1,
    CH_WRITE_WAIT = 2'd2,
    CH_RELEASE    = 2'd3
  } ch_state_e;

  // Index width for n slots; never below one bit so a single consumer still has a pointer.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_channel_fsm.sv
// One memory channel: latches a granted request, runs the memory handshake and
// waits for the consumer to let go before returning to IDLE.
module mem_channel_fsm
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int IDX_W        = 3,
  parameter int WRITE_ENABLE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 grant,
  input  logic                 grant_wr,
  input  logic [IDX_W-1:0]     grant_idx,
  input  logic [ADDR_BITS-1:0] grant_addr,
  input  logic [DATA_BITS-1:0] grant_data,
  input  logic                 release_ok,
  input  logic                 mem_read_ready,
  input  logic                 mem_write_ready,
  output logic                 idle,
  output logic                 rd_done,
  output logic                 wr_done,
  output logic                 rel_done,
  output logic [IDX_W-1:0]     cons_idx,
  output logic                 mem_read_valid,
  output logic [ADDR_BITS-1:0] mem_read_address,
  output logic                 mem_write_valid,
  output logic [ADDR_BITS-1:0] mem_write_address,
  output logic [DATA_BITS-1:0] mem_write_data
);

  ch_state_e             state_q;
  logic [IDX_W-1:0]      idx_q;
  logic [ADDR_BITS-1:0]  addr_q;
  logic [DATA_BITS-1:0]  wdata_q;
  logic                  rd_vld_q, wr_vld_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= CH_IDLE;
      idx_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_vld_q <= 1'b0;
      wr_vld_q <= 1'b0;
    end else begin
      case (state_q)
        CH_IDLE: if (grant) begin
          idx_q  <= grant_idx;
          addr_q <= grant_addr;
          if (grant_wr && (WRITE_ENABLE != 0)) begin
            wdata_q  <= grant_data;
            wr_vld_q <= 1'b1;
            state_q  <= CH_WRITE_WAIT;
          end else begin
            rd_vld_q <= 1'b1;
            state_q  <= CH_READ_WAIT;
          end
        end
        CH_READ_WAIT: if (mem_read_ready) begin
          rd_vld_q <= 1'b0;
          state_q  <= CH_RELEASE;
        end
        CH_WRITE_WAIT: if (mem_write_ready) begin
          wr_vld_q <= 1'b0;
          state_q  <= CH_RELEASE;
        end
        CH_RELEASE: if (release_ok) state_q <= CH_IDLE;
        default: state_q <= CH_IDLE;
      endcase
    end
  end

  assign idle     = (state_q == CH_IDLE);
  assign rd_done  = (state_q == CH_READ_WAIT) && mem_read_ready;
  assign wr_done  = (state_q == CH_WRITE_WAIT) && mem_write_ready;
  assign rel_done = (state_q == CH_RELEASE) && release_ok;
  assign cons_idx = idx_q;

  assign mem_read_valid    = rd_vld_q;
  assign mem_read_address  = addr_q;
  // Write outputs are tied off entirely in read-only builds.
  assign mem_write_valid   = (WRITE_ENABLE != 0) && wr_vld_q;
  assign mem_write_address = (WRITE_ENABLE != 0) ? addr_q  : '0;
  assign mem_write_data    = (WRITE_ENABLE != 0) ? wdata_q : '0;

endmodule

// File: rtl/rr_memory_controller.sv
// Round-robin arbiter between per-thread LSU request ports and independent
// memory channels; owns claims, the rotating pointer and consumer-side results.
module rr_memory_controller
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 8,
  parameter int NUM_CHANNELS  = 4,
  parameter int WRITE_ENABLE  = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]            mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
  output logic [NUM_CHANNELS-1:0]            mem_write_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
  output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
  input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);

  localparam int IDX_W = idx_w(NUM_CONSUMERS);

  logic [NUM_CONSUMERS-1:0]                wr_vld_eff, pend, claim_q, claim_nxt, rd_rdy_q, wr_rdy_q;
  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] rd_addr, wr_addr;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] wr_data, rdata_q;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_rdata;

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_nxt, last_idx, scan_idx;
  logic [IDX_W:0]   scan_sum, ptr_sum;
  logic             found, any_grant;

  logic [NUM_CHANNELS-1:0]                 ch_idle, ch_grant, ch_grant_wr;
  logic [NUM_CHANNELS-1:0]                 ch_rd_done, ch_wr_done, ch_rel_done, ch_rel_ok;
  logic [NUM_CHANNELS-1:0][IDX_W-1:0]      ch_grant_idx, ch_idx;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  ch_grant_addr;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  ch_grant_data;

  assign rd_addr    = consumer_read_address;
  assign wr_addr    = consumer_write_address;
  assign wr_data    = consumer_write_data;
  assign mem_rdata  = mem_read_data;
  assign wr_vld_eff = (WRITE_ENABLE != 0) ? consumer_write_valid : '0;
  assign pend       = consumer_read_valid | wr_vld_eff;

  // Channels claim in ascending order; claim_nxt carries this cycle's earlier grants.
  always_comb begin
    claim_nxt     = claim_q;
    ch_grant      = '0;
    ch_grant_wr   = '0;
    ch_grant_idx  = '0;
    ch_grant_addr = '0;
    ch_grant_data = '0;
    any_grant     = 1'b0;
    last_idx      = rr_ptr_q;
    found         = 1'b0;
    scan_sum      = '0;
    scan_idx      = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      found = 1'b0;
      for (int k = 0; k < NUM_CONSUMERS; k++) begin
        scan_sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
        if (scan_sum >= (IDX_W+1)'(NUM_CONSUMERS))
          scan_sum = scan_sum - (IDX_W+1)'(NUM_CONSUMERS);
        scan_idx = scan_sum[IDX_W-1:0];
        if (ch_idle[c] && !found && pend[scan_idx] && !claim_nxt[scan_idx]) begin
          found            = 1'b1;
          ch_grant[c]      = 1'b1;
          ch_grant_idx[c]  = scan_idx;
          ch_grant_wr[c]   = !consumer_read_valid[scan_idx];
          ch_grant_addr[c] = consumer_read_valid[scan_idx] ? rd_addr[scan_idx] : wr_addr[scan_idx];
          ch_grant_data[c] = wr_data[scan_idx];
          claim_nxt[scan_idx] = 1'b1;
          last_idx         = scan_idx;
          any_grant        = 1'b1;
        end
      end
    end
    for (int c = 0; c < NUM_CHANNELS; c++)
      if (ch_rel_done[c]) claim_nxt[ch_idx[c]] = 1'b0;
    ptr_sum = {1'b0, last_idx} + (IDX_W+1)'(1);
    if (ptr_sum >= (IDX_W+1)'(NUM_CONSUMERS)) ptr_sum = '0;
    rr_ptr_nxt = any_grant ? ptr_sum[IDX_W-1:0] : rr_ptr_q;
  end

  always_comb begin
    ch_rel_ok = '0;
    for (int c = 0; c < NUM_CHANNELS; c++)
      ch_rel_ok[c] = !consumer_read_valid[ch_idx[c]] && !wr_vld_eff[ch_idx[c]];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      claim_q  <= '0;
      rr_ptr_q <= '0;
      rd_rdy_q <= '0;
      wr_rdy_q <= '0;
      rdata_q  <= '0;
    end else begin
      claim_q  <= claim_nxt;
      rr_ptr_q <= rr_ptr_nxt;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (ch_rd_done[c]) begin
          rd_rdy_q[ch_idx[c]] <= 1'b1;
          rdata_q[ch_idx[c]]  <= mem_rdata[c];
        end
        if (ch_wr_done[c]) wr_rdy_q[ch_idx[c]] <= 1'b1;
        if (ch_rel_done[c]) begin
          rd_rdy_q[ch_idx[c]] <= 1'b0;
          wr_rdy_q[ch_idx[c]] <= 1'b0;
        end
      end
    end
  end

  assign consumer_read_ready  = rd_rdy_q;
  assign consumer_write_ready = wr_rdy_q;
  assign consumer_read_data   = rdata_q;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    mem_channel_fsm #(
      .ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS),
      .IDX_W(IDX_W), .WRITE_ENABLE(WRITE_ENABLE)
    ) u_fsm (
      .clk              (clk),
      .reset            (reset),
      .grant            (ch_grant[c]),
      .grant_wr         (ch_grant_wr[c]),
      .grant_idx        (ch_grant_idx[c]),
      .grant_addr       (ch_grant_addr[c]),
      .grant_data       (ch_grant_data[c]),
      .release_ok       (ch_rel_ok[c]),
      .mem_read_ready   (mem_read_ready[c]),
      .mem_write_ready  (mem_write_ready[c]),
      .idle             (ch_idle[c]),
      .rd_done          (ch_rd_done[c]),
      .wr_done          (ch_wr_done[c]),
      .rel_done         (ch_rel_done[c]),
      .cons_idx         (ch_idx[c]),
      .mem_read_valid   (mem_read_valid[c]),
      .mem_read_address (mem_read_address[c*ADDR_BITS +: ADDR_BITS]),
      .mem_write_valid  (mem_write_valid[c]),
      .mem_write_address(mem_write_address[c*ADDR_BITS +: ADDR_BITS]),
      .mem_write_data   (mem_write_data[c*DATA_BITS +: DATA_BITS])
    );
  end

endmodule

// File: tb/tb_rr_memory_controller.sv
// Bench for rr_memory_controller: directed scenarios plus randomized traffic
// against a memory whose read data is addr ^ 0x76.
module tb_rr_memory_controller;

  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;

  // main instance: 8 consumers, 4 channels, writes enabled
  logic [7:0]  crv, cwv, crr, cwr;
  logic [63:0] cra, cwa, cwd, crd;
  logic [3:0]  mrv, mrr, mwv, mwr;
  logic [31:0] mra, mrd, mwa, mwd;

  // second instance: 1 channel, read-only
  logic [7:0]  b_crv, b_cwv, b_crr, b_cwr;
  logic [63:0] b_cra, b_cwa, b_cwd, b_crd;
  logic        b_mrv, b_mrr, b_mwv, b_mwr;
  logic [7:0]  b_mra, b_mrd, b_mwa, b_mwd;

  rr_memory_controller #(.NUM_CHANNELS(4), .WRITE_ENABLE(1)) dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(crv), .consumer_read_address(cra),
    .consumer_read_ready(crr), .consumer_read_data(crd),
    .consumer_write_valid(cwv), .consumer_write_address(cwa),
    .consumer_write_data(cwd), .consumer_write_ready(cwr),
    .mem_read_valid(mrv), .mem_read_address(mra),
    .mem_read_ready(mrr), .mem_read_data(mrd),
    .mem_write_valid(mwv), .mem_write_address(mwa),
    .mem_write_data(mwd), .mem_write_ready(mwr));

  rr_memory_controller #(.NUM_CHANNELS(1), .WRITE_ENABLE(0)) dut_b (
    .clk(clk), .reset(reset),
    .consumer_read_valid(b_crv), .consumer_read_address(b_cra),
    .consumer_read_ready(b_crr), .consumer_read_data(b_crd),
    .consumer_write_valid(b_cwv), .consumer_write_address(b_cwa),
    .consumer_write_data(b_cwd), .consumer_write_ready(b_cwr),
    .mem_read_valid(b_mrv), .mem_read_address(b_mra),
    .mem_read_ready(b_mrr), .mem_read_data(b_mrd),
    .mem_write_valid(b_mwv), .mem_write_address(b_mwa),
    .mem_write_data(b_mwd), .mem_write_ready(b_mwr));

  int checks = 0, errors = 0;
  int lat_min = 0, lat_max = 0;
  bit resp_hold = 1'b0;
  logic [7:0] wr_log_data [8];
  logic [7:0] wr_log_addr [8];
  int         wr_log_cnt  [8];

  // Memory model: random latency per transaction, one-cycle ready pulse.
  initial begin : responder
    int cnt_r [4], cnt_w [4];
    bit busy_r [4], busy_w [4];
    logic [2:0] li;
    mrr = '0; mwr = '0; mrd = '0; b_mrr = 1'b0; b_mrd = '0;
    for (int i = 0; i < 8; i++) begin wr_log_cnt[i] = 0; wr_log_data[i] = '0; wr_log_addr[i] = '0; end
    forever begin
      @(negedge clk);
      if (!reset) begin
        mrr = '0; mwr = '0; b_mrr = 1'b0;
        for (int c = 0; c < 4; c++) begin busy_r[c] = 0; busy_w[c] = 0; end
      end else begin
        for (int c = 0; c < 4; c++) begin
          if (mrr[c]) begin mrr[c] = 1'b0; busy_r[c] = 0; end
          else if (mrv[c]) begin
            if (!busy_r[c]) begin busy_r[c] = 1; cnt_r[c] = int'($urandom_range(lat_max, lat_min)); end
            if (!resp_hold) begin
              if (cnt_r[c] == 0) begin mrr[c] = 1'b1; mrd[c*8 +: 8] = mra[c*8 +: 8] ^ 8'h76; end
              else cnt_r[c]--;
            end
          end
          if (mwr[c]) begin mwr[c] = 1'b0; busy_w[c] = 0; end
          else if (mwv[c]) begin
            if (!busy_w[c]) begin busy_w[c] = 1; cnt_w[c] = int'($urandom_range(lat_max, lat_min)); end
            if (!resp_hold) begin
              if (cnt_w[c] == 0) begin
                mwr[c] = 1'b1;
                li = mwa[c*8 +: 3];
                wr_log_data[li] = mwd[c*8 +: 8];
                wr_log_addr[li] = mwa[c*8 +: 8];
                wr_log_cnt[li]++;
              end else cnt_w[c]--;
            end
          end
        end
        if (b_mrr) b_mrr = 1'b0;
        else if (b_mrv) begin b_mrr = 1'b1; b_mrd = b_mra ^ 8'h76; end
      end
    end
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic clear_inputs();
    crv = '0; cwv = '0; cra = '0; cwa = '0; cwd = '0;
    b_crv = '0; b_cwv = '0; b_cra = '0; b_cwa = '0; b_cwd = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0; step(); step();
    reset = 1'b1; step();
  endtask

  task automatic test_reset();
    clear_inputs();
    b_mwr = 1'b0;
    reset = 1'b0;
    crv = 8'hFF; cra = 64'h0706050403020100;
    #1;
    checks++; if ({crr, cwr} !== 16'h0) begin errors++; $display("FAIL reset_cons_ready got %h want 0", {crr, cwr}); end
    checks++; if (crd !== 64'h0) begin errors++; $display("FAIL reset_cons_data got %h want 0", crd); end
    step(); step();
    checks++; if ({mrv, mwv} !== 8'h0) begin errors++; $display("FAIL reset_mem_valid got %h want 0", {mrv, mwv}); end
    checks++; if ({mra, mwa, mwd} !== 96'h0) begin errors++; $display("FAIL reset_mem_bus got %h want 0", {mra, mwa, mwd}); end
    checks++; if ({b_mrv, b_mwv, b_crr, b_cwr} !== 18'h0) begin errors++; $display("FAIL reset_b_outputs got %h want 0", {b_mrv, b_mwv, b_crr, b_cwr}); end
    clear_inputs();
  endtask

  task automatic test_single_read();
    int n;
    do_reset();
    lat_min = 2; lat_max = 2;
    crv[3] = 1'b1; cra[24 +: 8] = 8'h2A;
    step();
    checks++; if (mrv !== 4'b0001) begin errors++; $display("FAIL single_grant_ch got %b want 0001", mrv); end
    checks++; if (mra[7:0] !== 8'h2A) begin errors++; $display("FAIL single_addr got %h want 2a", mra[7:0]); end
    n = 0;
    while (!mrr[0] && n < 20) begin step(); n++; end
    checks++; if (!mrr[0]) begin errors++; $display("FAIL single_mem_ready_timeout got 0 want 1"); end
    checks++; if (crr[3] !== 1'b0 || mrv[0] !== 1'b1) begin errors++; $display("FAIL single_pre_ready got rdy=%b mv=%b want 0 1", crr[3], mrv[0]); end
    step();
    checks++; if (crr !== 8'h08 || mrv !== 4'h0) begin errors++; $display("FAIL single_ready got rdy=%h mv=%h want 08 0", crr, mrv); end
    checks++; if (crd[24 +: 8] !== 8'h5C) begin errors++; $display("FAIL single_data got %h want 5c", crd[24 +: 8]); end
    repeat (3) step();
    checks++; if (crr[3] !== 1'b1) begin errors++; $display("FAIL single_hold got %b want 1", crr[3]); end
    crv[3] = 1'b0;
    step();
    checks++; if (crr !== 8'h00) begin errors++; $display("FAIL single_release got %h want 00", crr); end
    checks++; if (crd[24 +: 8] !== 8'h5C) begin errors++; $display("FAIL single_data_hold got %h want 5c", crd[24 +: 8]); end
  endtask

  task automatic test_saturation();
    int rdy_cnt [8];
    int gch [8];
    int order [$];
    logic [3:0] prev_mv;
    logic [7:0] prev_rr;
    bit first;
    do_reset();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 8; i++) begin rdy_cnt[i] = 0; gch[i] = -1; cra[i*8 +: 8] = 8'h10 + 8'(i); end
    crv = 8'hFF;
    prev_mv = '0; prev_rr = '0; first = 1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      step();
      for (int c = 0; c < 4; c++)
        if (mrv[c] && !prev_mv[c]) begin
          gch[int'(mra[c*8 +: 3])] = c;
          order.push_back(int'(mra[c*8 +: 3]));
        end
      if (first && crr != 0) begin
        first = 0;
        checks++; if (crr !== 8'h0F) begin errors++; $display("FAIL sat_simultaneous got %h want 0f", crr); end
      end
      for (int i = 0; i < 8; i++)
        if (crr[i] && !prev_rr[i]) begin
          rdy_cnt[i]++;
          checks++;
          if (crd[i*8 +: 8] !== ((8'h10 + 8'(i)) ^ 8'h76)) begin errors++; $display("FAIL sat_data[%0d] got %h want %h", i, crd[i*8 +: 8], (8'h10 + 8'(i)) ^ 8'h76); end
          crv[i] = 1'b0;
        end
      prev_mv = mrv; prev_rr = crr;
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rdy_cnt[i] != 1 || gch[i] != i % 4) begin errors++; $display("FAIL sat_consumer[%0d] got ready_count=%0d channel=%0d want 1 %0d", i, rdy_cnt[i], gch[i], i % 4); end
    end
    checks++;
    if (order.size() != 8) begin errors++; $display("FAIL sat_grant_count got %0d want 8", order.size()); end
    else for (int i = 0; i < 8; i++) if (order[i] != i) begin errors++; $display("FAIL sat_order[%0d] got %0d want %0d", i, order[i], i); break; end
  endtask

  task automatic test_write();
    int n, snap;
    do_reset();
    lat_min = 0; lat_max = 2;
    snap = wr_log_cnt[0];
    cwv[5] = 1'b1; cwa[40 +: 8] = 8'h80; cwd[40 +: 8] = 8'h11;
    step();
    checks++; if (mwv !== 4'b0001 || mrv !== 4'b0000) begin errors++; $display("FAIL write_grant got mwv=%b mrv=%b want 0001 0000", mwv, mrv); end
    checks++; if (mwa[7:0] !== 8'h80 || mwd[7:0] !== 8'h11) begin errors++; $display("FAIL write_bus got a=%h d=%h want 80 11", mwa[7:0], mwd[7:0]); end
    n = 0;
    while (!cwr[5] && n < 20) begin step(); n++; end
    checks++; if (cwr !== 8'h20) begin errors++; $display("FAIL write_ready got %h want 20", cwr); end
    checks++; if (wr_log_cnt[0] != snap + 1 || wr_log_data[0] !== 8'h11 || wr_log_addr[0] !== 8'h80) begin errors++; $display("FAIL write_mem got n=%0d d=%h a=%h want %0d 11 80", wr_log_cnt[0] - snap, wr_log_data[0], wr_log_addr[0], 1); end
    cwv[5] = 1'b0;
    step();
    checks++; if (cwr !== 8'h00) begin errors++; $display("FAIL write_release got %h want 00", cwr); end
  endtask

  task automatic test_read_write_same();
    int n, snap;
    bit wr_early;
    do_reset();
    lat_min = 0; lat_max = 0;
    snap = wr_log_cnt[1];
    crv[1] = 1'b1; cra[8 +: 8] = 8'h33;
    cwv[1] = 1'b1; cwa[8 +: 8] = 8'h41; cwd[8 +: 8] = 8'h99;
    step();
    checks++; if (mrv !== 4'b0001 || mwv !== 4'b0000) begin errors++; $display("FAIL rw_read_first got mrv=%b mwv=%b want 0001 0000", mrv, mwv); end
    n = 0; wr_early = 0;
    while (!crr[1] && n < 20) begin step(); n++; if (mwv != 0) wr_early = 1; end
    checks++; if (crr[1] !== 1'b1 || crd[8 +: 8] !== 8'h45) begin errors++; $display("FAIL rw_read got rdy=%b d=%h want 1 45", crr[1], crd[8 +: 8]); end
    checks++; if (wr_early || cwr !== 8'h00) begin errors++; $display("FAIL rw_write_overlap got early=%0d wrdy=%h want 0 00", wr_early, cwr); end
    crv[1] = 1'b0; cwv[1] = 1'b0;
    step();
    cwv[1] = 1'b1;
    n = 0;
    while (!cwr[1] && n < 20) begin step(); n++; end
    checks++; if (cwr[1] !== 1'b1 || wr_log_cnt[1] != snap + 1 || wr_log_data[1] !== 8'h99 || wr_log_addr[1] !== 8'h41) begin errors++; $display("FAIL rw_write got rdy=%b d=%h a=%h want 1 99 41", cwr[1], wr_log_data[1], wr_log_addr[1]); end
    cwv[1] = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_read();
    int n;
    do_reset();
    lat_min = 0; lat_max = 0;
    resp_hold = 1'b1;
    crv[2] = 1'b1; cra[16 +: 8] = 8'h55;
    repeat (3) step();
    checks++; if (mrv !== 4'b0001) begin errors++; $display("FAIL midrst_busy got %b want 0001", mrv); end
    reset = 1'b0;
    #1;
    checks++; if ({crr, cwr, crd, mrv, mwv, mra, mwa, mwd} !== 184'h0) begin errors++; $display("FAIL midrst_clear got rr=%h mv=%h ma=%h want 0", crr, mrv, mra); end
    crv = '0;
    step();
    reset = 1'b1; resp_hold = 1'b0;
    step();
    checks++; if (crr !== 8'h00 || mrv !== 4'h0) begin errors++; $display("FAIL midrst_no_ready got rr=%h mv=%h want 00 0", crr, mrv); end
    crv[1] = 1'b1; cra[8 +: 8] = 8'h61;
    crv[6] = 1'b1; cra[48 +: 8] = 8'h66;
    step();
    checks++; if (mra[15:0] !== 16'h6661) begin errors++; $display("FAIL midrst_ptr0 got %h want 6661", mra[15:0]); end
    n = 0;
    while (crv != 0 && n < 30) begin
      step(); n++;
      for (int i = 0; i < 8; i++) if (crr[i]) crv[i] = 1'b0;
    end
    checks++; if (crv !== 8'h00) begin errors++; $display("FAIL midrst_drain got %h want 00", crv); end
  endtask

  task automatic test_fairness();
    int grants [$];
    int k;
    logic prev;
    bit wr_seen;
    do_reset();
    b_crv[0] = 1'b1; b_cra[7:0] = 8'h00;
    b_crv[7] = 1'b1; b_cra[63:56] = 8'h70;
    prev = 1'b0; k = 1; wr_seen = 0;
    for (int cyc = 0; cyc < 100 && grants.size() < 6; cyc++) begin
      step();
      if (b_mwv) wr_seen = 1;
      if (b_mrv && !prev) grants.push_back(int'(b_mra[7:4]));
      prev = b_mrv;
      for (int j = 0; j < 2; j++) begin
        int i;
        i = (j == 0) ? 0 : 7;
        if (b_crv[i] && b_crr[i]) begin
          checks++;
          if (b_crd[i*8 +: 8] !== (b_cra[i*8 +: 8] ^ 8'h76)) begin errors++; $display("FAIL fair_data[%0d] got %h want %h", i, b_crd[i*8 +: 8], b_cra[i*8 +: 8] ^ 8'h76); end
          b_crv[i] = 1'b0;
        end else if (!b_crv[i] && !b_crr[i]) begin
          b_crv[i] = 1'b1; b_cra[i*8 +: 8] = 8'(i * 16 + (k % 16)); k++;
        end
      end
    end
    checks++;
    if (grants.size() != 6) begin errors++; $display("FAIL fair_count got %0d want 6", grants.size()); end
    else for (int i = 0; i < 6; i++)
      if (grants[i] != ((i % 2) ? 7 : 0)) begin errors++; $display("FAIL fair_order[%0d] got %0d want %0d", i, grants[i], (i % 2) ? 7 : 0); break; end
    checks++; if (wr_seen) begin errors++; $display("FAIL fair_write_valid got 1 want 0"); end
    b_crv = '0;
    repeat (6) step();
  endtask

  task automatic test_no_write();
    bit seen;
    do_reset();
    b_cwv[2] = 1'b1; b_cwa[16 +: 8] = 8'h90; b_cwd[16 +: 8] = 8'h3C;
    seen = 0;
    repeat (10) begin
      step();
      if (b_mwv || b_mrv || b_cwr != 0 || b_mwa != 0 || b_mwd != 0) seen = 1;
    end
    checks++; if (seen) begin errors++; $display("FAIL nowrite_activity got 1 want 0"); end
    b_cwv = '0;
  endtask

  task automatic test_random();
    int st [8], age [8], snap [8];
    logic [7:0] ea [8], ed [8];
    do_reset();
    lat_min = 0; lat_max = 3;
    for (int i = 0; i < 8; i++) begin st[i] = 0; age[i] = 0; end
    for (int cyc = 0; cyc < 700; cyc++) begin
      step();
      for (int i = 0; i < 8; i++) begin
        case (st[i])
          0: begin
            checks++;
            if (crr[i] || cwr[i]) begin errors++; $display("FAIL rand_spurious[%0d] got rr=%b wr=%b want 0 0", i, crr[i], cwr[i]); end
            if (cyc < 550 && ($urandom % 4) == 0) begin
              age[i] = 0;
              if (($urandom % 3) == 0) begin
                ea[i] = {5'($urandom), 3'(i)}; ed[i] = 8'($urandom);
                snap[i] = wr_log_cnt[i];
                cwa[i*8 +: 8] = ea[i]; cwd[i*8 +: 8] = ed[i]; cwv[i] = 1'b1; st[i] = 2;
              end else begin
                ea[i] = 8'($urandom);
                cra[i*8 +: 8] = ea[i]; crv[i] = 1'b1; st[i] = 1;
              end
            end
          end
          1, 2: begin
            if ((st[i] == 1 && crr[i]) || (st[i] == 2 && cwr[i])) begin
              checks++;
              if (st[i] == 1 && crd[i*8 +: 8] !== (ea[i] ^ 8'h76)) begin errors++; $display("FAIL rand_read[%0d] got %h want %h", i, crd[i*8 +: 8], ea[i] ^ 8'h76); end
              if (st[i] == 2 && (wr_log_cnt[i] != snap[i] + 1 || wr_log_data[i] !== ed[i] || wr_log_addr[i] !== ea[i])) begin errors++; $display("FAIL rand_write[%0d] got d=%h a=%h want %h %h", i, wr_log_data[i], wr_log_addr[i], ed[i], ea[i]); end
              crv[i] = 1'b0; cwv[i] = 1'b0; st[i] = 3;
            end else if (++age[i] > 150) begin
              checks++; errors++; $display("FAIL rand_timeout[%0d] got no ready want ready", i);
              crv[i] = 1'b0; cwv[i] = 1'b0; st[i] = 3;
            end
          end
          default: begin
            checks++;
            if (crr[i] || cwr[i]) begin errors++; $display("FAIL rand_release[%0d] got rr=%b wr=%b want 0 0", i, crr[i], cwr[i]); end
            st[i] = 0;
          end
        endcase
      end
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (st[i] != 0) begin errors++; $display("FAIL rand_drain[%0d] got state %0d want 0", i, st[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_saturation();
    test_write();
    test_read_write_same();
    test_reset_mid_read();
    test_fairness();
    test_no_write();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
